// File: rtl/cipher_apb_wrapper_gen_pkg.sv
// Shared constants and types for the APB block-cipher wrapper.
package cipher_apb_wrapper_gen_pkg;

    // Byte lanes of the CONTROL register
    localparam int CTRL_RST     = 0;
    localparam int CTRL_REQ_ACK = 1;
    localparam int CTRL_VALID   = 2;
    localparam int CTRL_BUSY    = 3;

    // Bit positions of the IRQ/MODE register
    localparam int IRQ_EN   = 0;
    localparam int IRQ_PEND = 1;
    localparam int IRQ_AUTO = 2;

    // Default register placement
    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_DIN_ADDR  = 32'h0000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // One status flag presented in the low bit of a CONTROL byte lane
    function automatic logic [7:0] flag_byte(input logic flag);
        return {7'b0, flag};
    endfunction

endpackage

// File: rtl/cipher_apb_regfile.sv
// APB handshake, address decode, DATA_IN/DATA_OUT word storage and
// illegal-access detection for the cipher wrapper.
module cipher_apb_regfile
    import cipher_apb_wrapper_gen_pkg::*;
#(
    parameter int                BLOCK_W   = 128,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
    parameter logic [ADDR_W-1:0] DIN_ADDR  = ADDR_W'(4),
    parameter logic [ADDR_W-1:0] DOUT_ADDR = ADDR_W'(20),
    parameter logic [ADDR_W-1:0] IRQ_ADDR  = ADDR_W'(36)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [31:0]        pwdata,
    input  logic               idle,
    input  logic               rst_bit,
    input  logic               auto_en,
    input  logic [31:0]        ctrl_rd,
    input  logic [31:0]        irq_rd,
    input  logic               cap,
    input  logic [BLOCK_W-1:0] cap_data,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               wr_fire,
    output logic               wr_ok,
    output logic               sel_ctrl,
    output logic               sel_irq,
    output logic               sel_last,
    output logic [BLOCK_W-1:0] din
);

    localparam int NW = BLOCK_W / 32;

    logic [BLOCK_W-1:0] dout;
    logic [NW-1:0]      din_hit;
    logic [NW-1:0]      dout_hit;
    logic               access;
    logic               mapped;
    logic               rd_err;
    logic               wr_err;
    logic [31:0]        rd_val;
    logic               ready_p1;
    logic               err_p1;
    logic [31:0]        rdata_p1;

    // Decode the address into register windows and classify illegal accesses
    always_comb begin
        sel_ctrl = (paddr == CTRL_ADDR);
        sel_irq  = (paddr == IRQ_ADDR);
        din_hit  = '0;
        dout_hit = '0;
        rd_val   = '0;
        for (int k = 0; k < NW; k++) begin
            din_hit[k]  = (paddr == DIN_ADDR + ADDR_W'(4 * k));
            dout_hit[k] = (paddr == DOUT_ADDR + ADDR_W'(4 * k));
            if (din_hit[k])  rd_val = din[32*k +: 32];
            if (dout_hit[k]) rd_val = dout[32*k +: 32];
        end
        if (sel_ctrl) rd_val = ctrl_rd;
        if (sel_irq)  rd_val = irq_rd;
        sel_last = din_hit[NW-1];
        mapped   = (paddr[1:0] == 2'b00) & (sel_ctrl | sel_irq | (|din_hit) | (|dout_hit));
        rd_err   = !mapped;
        // A start is refused when busy or when RST is held or being set by the same write
        wr_err   = rd_err | (|dout_hit) | ((|din_hit) & !idle)
                 | (sel_last & auto_en & rst_bit)
                 | (sel_ctrl & pwdata[8*CTRL_REQ_ACK]
                    & (!idle | rst_bit | pwdata[8*CTRL_RST]));
    end

    assign access  = psel & penable;
    assign pready  = access & ready_p1;
    assign wr_fire = pready & pwrite;
    assign wr_ok   = wr_fire & !wr_err;
    assign pslverr = pready & (pwrite ? wr_err : err_p1);
    assign prdata  = rdata_p1;

    // Writes are readied from SETUP, reads from the first ACCESS cycle (one wait state)
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_p1 <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            if (pready || !psel) begin
                ready_p1 <= 1'b0;
            end else if (penable || pwrite) begin
                ready_p1 <= 1'b1;
            end
            if (access && !ready_p1 && !pwrite) begin
                err_p1   <= rd_err;
                rdata_p1 <= rd_err ? 32'h0 : rd_val;
            end
        end
    end

    // Plaintext words from APB, result block from the core
    always_ff @(posedge clk) begin
        if (rst) begin
            din  <= '0;
            dout <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_ok && din_hit[k]) din[32*k +: 32] <= pwdata;
            end
            if (cap) dout <= cap_data;
        end
    end

endmodule

// File: rtl/cipher_apb_wrapper_gen.sv
// APB3 slave wrapper around a block-cipher core: start handshake FSM,
// auto-start mode and maskable completion interrupt.
module cipher_apb_wrapper_gen
    import cipher_apb_wrapper_gen_pkg::*;
#(
    parameter int                BLOCK_W   = 128,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEF_CTRL_ADDR),
    parameter logic [ADDR_W-1:0] DIN_ADDR  = ADDR_W'(DEF_DIN_ADDR),
    parameter logic [ADDR_W-1:0] DOUT_ADDR = DIN_ADDR + ADDR_W'(4 * (BLOCK_W / 32)),
    parameter logic [ADDR_W-1:0] IRQ_ADDR  = DOUT_ADDR + ADDR_W'(4 * (BLOCK_W / 32))
) (
    input  logic               pclk_i,
    input  logic               prst_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [ADDR_W-1:0]  paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    output logic               core_rst_o,
    output logic               core_req_o,
    input  logic               core_ack_i,
    output logic [BLOCK_W-1:0] core_data_o,
    input  logic               core_valid_i,
    input  logic               core_busy_i,
    input  logic [BLOCK_W-1:0] core_data_i,
    output logic               irq_o
);

    state_t      state;
    logic        rst_bit;
    logic        valid;
    logic        pend;
    logic        irq_en;
    logic        auto_en;
    logic        wr_fire;
    logic        wr_ok;
    logic        sel_ctrl;
    logic        sel_irq;
    logic        sel_last;
    logic        start;
    logic        rst_now;
    logic        cap;
    logic [31:0] ctrl_rd;
    logic [31:0] irq_rd;

    cipher_apb_regfile #(
        .BLOCK_W   (BLOCK_W),
        .ADDR_W    (ADDR_W),
        .CTRL_ADDR (CTRL_ADDR),
        .DIN_ADDR  (DIN_ADDR),
        .DOUT_ADDR (DOUT_ADDR),
        .IRQ_ADDR  (IRQ_ADDR)
    ) u_regfile (
        .clk      (pclk_i),
        .rst      (prst_i),
        .psel     (psel_i),
        .penable  (penable_i),
        .pwrite   (pwrite_i),
        .paddr    (paddr_i),
        .pwdata   (pwdata_i),
        .idle     (state == IDLE),
        .rst_bit  (rst_bit),
        .auto_en  (auto_en),
        .ctrl_rd  (ctrl_rd),
        .irq_rd   (irq_rd),
        .cap      (cap),
        .cap_data (core_data_i),
        .prdata   (prdata_o),
        .pready   (pready_o),
        .pslverr  (pslverr_o),
        .wr_fire  (wr_fire),
        .wr_ok    (wr_ok),
        .sel_ctrl (sel_ctrl),
        .sel_irq  (sel_irq),
        .sel_last (sel_last),
        .din      (core_data_o)
    );

    // Start/reset/capture qualifiers and register read views
    always_comb begin
        start   = wr_ok & ((sel_ctrl & pwdata_i[8*CTRL_REQ_ACK]) | (sel_last & auto_en));
        rst_now = wr_fire & sel_ctrl & pwdata_i[8*CTRL_RST];
        cap     = (state == WAIT) & core_valid_i & !rst_now & !rst_bit;
        ctrl_rd = '0;
        ctrl_rd[8*CTRL_RST     +: 8] = flag_byte(rst_bit);
        ctrl_rd[8*CTRL_REQ_ACK +: 8] = flag_byte(state == REQ);
        ctrl_rd[8*CTRL_VALID   +: 8] = flag_byte(valid);
        ctrl_rd[8*CTRL_BUSY    +: 8] = flag_byte(core_busy_i | (state != IDLE));
        irq_rd  = '0;
        irq_rd[IRQ_EN]   = irq_en;
        irq_rd[IRQ_PEND] = pend;
        irq_rd[IRQ_AUTO] = auto_en;
    end

    // Control state and the request handshake; completion setting PEND beats a same-cycle W1C
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state      <= IDLE;
            core_req_o <= 1'b0;
            rst_bit    <= 1'b0;
            valid      <= 1'b0;
            pend       <= 1'b0;
            irq_en     <= 1'b0;
            auto_en    <= 1'b0;
        end else begin
            // RST is still taken from a CONTROL write whose start part was refused
            if (wr_fire && sel_ctrl && (wr_ok || pwdata_i[8*CTRL_RST])) begin
                rst_bit <= pwdata_i[8*CTRL_RST];
            end
            if (wr_ok && sel_irq) begin
                irq_en  <= pwdata_i[IRQ_EN];
                auto_en <= pwdata_i[IRQ_AUTO];
                if (pwdata_i[IRQ_PEND]) pend <= 1'b0;
            end
            if (rst_now || rst_bit) begin
                state      <= IDLE;
                core_req_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state      <= REQ;
                        core_req_o <= 1'b1;
                        valid      <= 1'b0;
                    end
                    REQ: if (core_ack_i) begin
                        state      <= WAIT;
                        core_req_o <= 1'b0;
                    end
                    WAIT: if (core_valid_i) begin
                        state <= IDLE;
                        valid <= 1'b1;
                        pend  <= 1'b1;
                    end
                    default: begin
                        state      <= IDLE;
                        core_req_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign core_rst_o = rst_bit;
    assign irq_o      = irq_en & pend;

endmodule

// File: tb/tb_cipher_apb_wrapper_gen.sv
// Directed bench for cipher_apb_wrapper_gen: a 128-bit and a 256-bit
// instance share the APB bus, each with its own select and stub core.
module tb_cipher_apb_wrapper_gen;

    logic         clk = 1'b0;
    logic         prst;
    logic [1:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata0, prdata1;
    logic         pready0, pready1, pslverr0, pslverr1;
    logic         core_rst0, core_rst1, core_req0, core_req1;
    logic [1:0]   ack, cvalid, busy;
    logic [127:0] cdo0, cdi0;
    logic [255:0] cdo1, cdi1;
    logic         irq0, irq1;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] PT128 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] PT2   = 128'h12345678_BBAA9988_77665544_33221100;
    localparam logic [127:0] SAME  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    always #5 clk = ~clk;

    cipher_apb_wrapper_gen dut0 (
        .pclk_i(clk), .prst_i(prst), .psel_i(psel[0]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0),
        .pready_o(pready0), .pslverr_o(pslverr0), .core_rst_o(core_rst0),
        .core_req_o(core_req0), .core_ack_i(ack[0]), .core_data_o(cdo0),
        .core_valid_i(cvalid[0]), .core_busy_i(busy[0]), .core_data_i(cdi0), .irq_o(irq0)
    );

    cipher_apb_wrapper_gen #(.BLOCK_W(256)) dut1 (
        .pclk_i(clk), .prst_i(prst), .psel_i(psel[1]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata1),
        .pready_o(pready1), .pslverr_o(pslverr1), .core_rst_o(core_rst1),
        .core_req_o(core_req1), .core_ack_i(ack[1]), .core_data_o(cdo1),
        .core_valid_i(cvalid[1]), .core_busy_i(busy[1]), .core_data_i(cdi1), .irq_o(irq1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input int d, input logic [31:0] a, input logic [31:0] v,
                             output logic err);
        logic done;
        done = 1'b0;
        err  = 1'b0;
        @(negedge clk);
        psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if ((d == 1) ? pready1 : pready0) begin
                done = 1'b1;
                err  = (d == 1) ? pslverr1 : pslverr0;
            end
            @(negedge clk);
        end
        psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        chk("apb_write_ready", done, 1);
    endtask

    task automatic apb_read(input int d, input logic [31:0] a, output logic [31:0] data,
                            output logic err);
        logic done;
        done = 1'b0;
        err  = 1'b0;
        data = 32'hx;
        @(negedge clk);
        psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if ((d == 1) ? pready1 : pready0) begin
                done = 1'b1;
                err  = (d == 1) ? pslverr1 : pslverr0;
                data = (d == 1) ? prdata1 : prdata0;
            end
            @(negedge clk);
        end
        psel = 2'b00; penable = 1'b0;
        chk("apb_read_ready", done, 1);
    endtask

    // Stub core: acknowledge two cycles after the request is seen
    task automatic core_accept(input int d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if ((d == 1) ? core_req1 : core_req0) seen = 1'b1;
            else @(negedge clk);
        end
        chk("core_req_seen", seen, 1);
        @(negedge clk);
        @(negedge clk);
        ack[d] = 1'b1;
        @(negedge clk);
        ack[d] = 1'b0;
    endtask

    // Stub core: deliver the result as a single-cycle valid pulse
    task automatic core_finish(input int d, input logic [255:0] data);
        repeat (4) @(negedge clk);
        if (d == 1) cdi1 = data;
        else        cdi0 = data[127:0];
        cvalid[d] = 1'b1;
        @(negedge clk);
        cvalid[d] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         err;
        logic [31:0]  rd;
        logic [255:0] pt256;

        prst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ack = '0; cvalid = '0; busy = '0;
        cdi0 = '0; cdi1 = '0; pt256 = '0;
        repeat (3) @(negedge clk);
        chk("rst_prdata", prdata0, 0);
        chk("rst_pready", pready0, 0);
        chk("rst_pslverr", pslverr0, 0);
        chk("rst_core_req", core_req0, 0);
        chk("rst_core_rst", core_rst0, 0);
        chk("rst_irq", irq0, 0);
        chk("rst_core_data", cdo0, 0);
        prst = 1'b0;

        // Basic encrypt round-trip
        apb_write(0, 32'h04, 32'h33221100, err); chk("din0_err", err, 0);
        apb_write(0, 32'h08, 32'h77665544, err);
        apb_write(0, 32'h0C, 32'hBBAA9988, err);
        apb_write(0, 32'h10, 32'hFFEEDDCC, err);
        chk("core_data_o", cdo0, PT128);
        apb_write(0, 32'h00, 32'h100, err); chk("start_err", err, 0);
        apb_read(0, 32'h00, rd, err);       chk("ctrl_in_req", rd, 32'h0100_0100);
        core_accept(0);
        core_finish(0, {128'h0, ~PT128});
        apb_read(0, 32'h14, rd, err);       chk("dout0", rd, 32'hCCDDEEFF);
        apb_read(0, 32'h20, rd, err);       chk("dout3", rd, 32'h00112233);
        apb_read(0, 32'h00, rd, err);       chk("ctrl_done", rd, 32'h0001_0000);
        chk("irq_masked", irq0, 0);
        apb_read(0, 32'h24, rd, err);       chk("irq_reg_pend", rd, 32'h2);
        busy[0] = 1'b1;
        apb_read(0, 32'h00, rd, err);       chk("ctrl_core_busy", rd, 32'h0101_0000);
        busy[0] = 1'b0;

        // Illegal accesses
        apb_read(0, 32'h02, rd, err);       chk("unaligned_err", err, 1);
        chk("unaligned_data", rd, 0);
        apb_read(0, 32'h100, rd, err);      chk("unmapped_err", err, 1);
        apb_write(0, 32'h14, 32'hDEADBEEF, err); chk("dout_wr_err", err, 1);
        apb_read(0, 32'h14, rd, err);       chk("dout_kept", rd, 32'hCCDDEEFF);

        // Auto-start from the last DATA_IN word
        apb_write(0, 32'h24, 32'h7, err);   chk("irq_cleared", irq0, 0);
        apb_write(0, 32'h10, 32'h12345678, err); chk("auto_wr_err", err, 0);
        chk("auto_core_data", cdo0, PT2);
        core_accept(0);
        apb_write(0, 32'h04, 32'hAAAA5555, err); chk("din_busy_err", err, 1);
        apb_read(0, 32'h04, rd, err);       chk("din_kept", rd, 32'h33221100);
        apb_write(0, 32'h00, 32'h100, err); chk("start_busy_err", err, 1);
        apb_read(0, 32'h00, rd, err);       chk("ctrl_in_wait", rd, 32'h0100_0000);
        core_finish(0, {128'h0, ~PT2});
        chk("irq_raised", irq0, 1);
        apb_read(0, 32'h20, rd, err);       chk("auto_dout3", rd, 32'hEDCBA987);
        apb_write(0, 32'h24, 32'h2, err);   chk("irq_w1c", irq0, 0);
        apb_read(0, 32'h24, rd, err);       chk("irq_reg_clear", rd, 32'h0);

        // Completion and PEND W1C on the same edge
        apb_write(0, 32'h24, 32'h1, err);
        apb_write(0, 32'h00, 32'h100, err);
        core_accept(0);
        @(negedge clk);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h3;
        @(negedge clk);
        penable = 1'b1; cvalid[0] = 1'b1; cdi0 = SAME;
        #1 chk("w1c_ready", pready0, 1);
        @(negedge clk);
        psel = 2'b00; penable = 1'b0; pwrite = 1'b0; cvalid[0] = 1'b0;
        chk("same_cycle_irq", irq0, 1);
        apb_read(0, 32'h24, rd, err);       chk("same_cycle_reg", rd, 32'h3);
        apb_read(0, 32'h14, rd, err);       chk("same_cycle_dout", rd, 32'h76543210);

        // RST while the core is working
        apb_write(0, 32'h24, 32'h2, err);
        apb_write(0, 32'h00, 32'h100, err);
        core_accept(0);
        apb_write(0, 32'h00, 32'h1, err);   chk("rst_wr_err", err, 0);
        chk("core_rst_set", core_rst0, 1);
        apb_read(0, 32'h00, rd, err);       chk("ctrl_after_rst", rd, 32'h0000_0001);
        core_finish(0, {128'h0, {4{32'h5555AAAA}}});
        apb_read(0, 32'h24, rd, err);       chk("no_pend_after_rst", rd, 32'h0);
        apb_read(0, 32'h00, rd, err);       chk("no_valid_after_rst", rd, 32'h0000_0001);
        apb_read(0, 32'h14, rd, err);       chk("dout_after_rst", rd, 32'h76543210);
        apb_write(0, 32'h00, 32'h100, err); chk("start_in_rst_err", err, 1);
        chk("rst_held", core_rst0, 1);
        apb_write(0, 32'h00, 32'h0, err);   chk("rst_released", core_rst0, 0);
        apb_write(0, 32'h00, 32'h101, err); chk("start_rst_err", err, 1);
        chk("rst_wins", core_rst0, 1);
        chk("rst_wins_no_req", core_req0, 0);
        apb_write(0, 32'h00, 32'h0, err);

        // Bus reset in the middle of a write
        @(negedge clk);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFFFFFFFF;
        @(negedge clk);
        penable = 1'b1; prst = 1'b1;
        @(negedge clk);
        chk("midrst_pready", pready0, 0);
        chk("midrst_core_rst", core_rst0, 0);
        chk("midrst_core_data", cdo0, 0);
        prst = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        apb_read(0, 32'h08, rd, err);       chk("midrst_din1", rd, 32'h0);
        apb_read(0, 32'h00, rd, err);       chk("midrst_ctrl", rd, 32'h0);

        // 256-bit instance round-trip
        for (int k = 0; k < 8; k++) begin
            apb_write(1, 32'h04 + 32'(4 * k), 32'hA0A0_0000 + 32'(k), err);
            pt256[32*k +: 32] = 32'hA0A0_0000 + 32'(k);
        end
        chk("w256_core_data", cdo1, pt256);
        chk("w256_word7", cdo1[255:224], 32'hA0A0_0007);
        apb_write(1, 32'h00, 32'h100, err); chk("w256_start_err", err, 0);
        core_accept(1);
        core_finish(1, ~pt256);
        apb_read(1, 32'h24, rd, err);       chk("w256_dout0", rd, 32'h5F5F_FFFF);
        apb_read(1, 32'h40, rd, err);       chk("w256_dout7", rd, 32'h5F5F_FFF8);
        apb_read(1, 32'h44, rd, err);       chk("w256_irq_reg", rd, 32'h2);
        apb_read(1, 32'h48, rd, err);       chk("w256_unmapped", err, 1);
        apb_read(1, 32'h00, rd, err);       chk("w256_ctrl", rd, 32'h0001_0000);
        chk("w256_irq", irq1, 0);
        chk("w256_core_rst", core_rst1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
